rdadd_pipe: RTL
===============

# rdadd_pipe

Parametrised, pipelined recursive-doubling (kill/propagate/generate) adder/subtractor for the ALU datapath. It generalises the fixed 8-bit recursive-doubling stage to any power-of-two WIDTH. Each doubling level is registered, one operation is accepted per clock, and a valid/ready handshake with backpressure is provided. Results carry cout, signed overflow and zero flags for the status register.

## Interface
- WIDTH, 16, operand width; power of two, ≥ 2.
- LOG2W, derived localparam, log2(WIDTH); sets the number of doubling stages.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  0: a+b+cin; 1: a-b (computed as a+~b+1; cin ignored).
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  out  1  signed overflow: c[WIDTH] XOR c[WIDTH-1].
- zero  out  1  sum == 0.

## Operation
- KPG encoding is 2 bits per position: kill = 00, generate = 11, propagate = 01 or 10.
- Stage G (input register), per bit i:
  - b' = sub ? ~b : b; c0 = sub ? 1 : cin.
  - kpg[i] = {a[i], b'[i]}; p[i] = a[i] ^ b'[i], carried forward for the sum.
  - Position 0 is pre-resolved: if kpg[0] is propagate, it is replaced with {c0, c0}.
- Doubling stages D1..D(LOG2W); stage s uses distance d = 2^(s-1):
  - For i ≥ d: if kpg[i] is kill or generate, keep it; otherwise take kpg[i-d].
  - For i < d: pass through unchanged.
  - After LOG2W stages every position is kill or generate. Carry out of bit i is c[i+1] = kpg[i][0].
- Stage S (output register):
  - sum[i] = p[i] ^ c[i], with c[0] = c0.
  - cout = c[WIDTH]; ovf = c[WIDTH] ^ c[WIDTH-1]; zero = ~|sum.
- c0, p, a valid bit and the sub flag travel alongside kpg through every stage.
- Pipeline control uses one global advance enable: adv = out_ready | ~out_valid.
  - All stage registers and valid bits load only when adv = 1.
  - in_ready = adv (combinational from out_ready and out_valid).
- A beat is accepted when in_valid & in_ready.
- Bubbles (valid=0 stages) are not collapsed while stalled. Throughput is 1 beat per cycle when out_ready is held high.
- Order is strictly preserved; no beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+LOG2W+1, i.e. LOG2W+2 register stages in total. WIDTH=16 gives 6 stages; WIDTH=8 gives 5.
- Reset (rst=1 at an edge):
  - All valid bits clear; sum=0, cout=0, ovf=0, zero=0, out_valid=0.
  - In-flight beats are discarded with no partial output.
  - in_ready=1 in the first cycle after reset.
- rst has priority over adv at the same edge.
- Stall: while out_valid=1 and out_ready=0, sum, cout, ovf, zero and out_valid hold exactly, in_ready=0, and no internal stage changes.
- Stall release: the held beat is consumed at the first edge with out_ready=1. The next beat, if any, is presented in the following cycle.
- Upstream: a and b need not be held after acceptance. Offered data may change freely while in_ready=0.
- Boundary cases:
  - A full propagate chain (a=~b, sub=0) resolves within LOG2W stages for any cin.
  - cin=1 with all-ones propagate gives sum=0, cout=1.

## Test plan
- WIDTH=16, add, a=0x00FF, b=0x0001, cin=0, out_ready=1 → after 6 cycles: sum=0x0100, cout=0, ovf=0, zero=0.
- Add, a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, zero=1. Then a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Sub, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. Then sub, a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1. In both cases cin=1 is applied and must be ignored.
- 10 back-to-back beats with out_ready=1 → results on 10 consecutive cycles, in order. Then drop out_ready for 3 cycles mid-stream → outputs held stable, in_ready=0, no beat lost or duplicated.
- Assert rst for one cycle with 4 beats in flight → out_valid=0 and all flags 0 on the next cycle. No stale result ever emerges. in_ready=1.
- WIDTH=8 instance, 10k random (a, b, cin, sub) beats with random out_ready → every result matches a behavioural a+b+cin / a-b model including cout and ovf. Latency is 5 whenever no stall occurs.

Source files
------------

// File: rtl/rdadd_pipe.sv
// rdadd_pipe: pipelined recursive-doubling (kill/propagate/generate) adder /
// subtractor with a valid/ready handshake.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   operand beat handshake (in_ready = global advance)
//   a, b [WIDTH]          operands
//   cin                   carry-in for add; ignored when sub=1
//   sub                   0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid / out_ready result beat handshake
//   sum [WIDTH]           result modulo 2^WIDTH
//   cout                  carry out of MSB (1 = no borrow when subtracting)
//   ovf                   signed overflow, c[WIDTH] ^ c[WIDTH-1]
//   zero                  sum == 0
//
// Pipeline: G (operand encode) -> D1..D(LOG2W) (doubling levels) -> S (sum).
// Every register advances on one shared enable, so a stall freezes the whole
// pipe and bubbles are never collapsed.

// One doubling level: a position still propagating inherits the KPG state of
// the position DIST below it; resolved (kill/generate) positions are kept.
module rdadd_dbl #(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0][1:0] kpg_i,
   output logic [WIDTH-1:0][1:0] kpg_o
);
   always_comb begin
      kpg_o = kpg_i;
      for (int i = DIST; i < WIDTH; i++)
         if (kpg_i[i][1] != kpg_i[i][0]) kpg_o[i] = kpg_i[i-DIST];
   end
endmodule

module rdadd_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int LOG2W = $clog2(WIDTH);

   // sub is folded entirely into b' and c0 at stage G, so only c0 and the
   // propagate bits need to travel with the KPG vector.
   typedef struct packed {
      logic [WIDTH-1:0][1:0] kpg;
      logic [WIDTH-1:0]      p;
      logic                  c0;
   } stg_t;

   stg_t                  stg_q [LOG2W+1];   // [0] = G, [s] = Ds
   logic [LOG2W:0]        vld_pipe;
   logic [WIDTH-1:0][1:0] kpg_dbl [1:LOG2W];
   stg_t                  g_d;
   logic [WIDTH-1:0]      bx;
   logic                  c0;
   logic [WIDTH:0]        c;
   logic [WIDTH-1:0]      s_sum;
   logic                  adv;

   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // Stage G encode. Bit 0 is pre-resolved against c0 so that after LOG2W
   // doublings every position is kill or generate.
   always_comb begin
      bx      = sub ? ~b : b;
      c0      = sub | cin;
      g_d.p   = a ^ bx;
      g_d.c0  = c0;
      for (int i = 0; i < WIDTH; i++) g_d.kpg[i] = {a[i], bx[i]};
      if (g_d.p[0]) g_d.kpg[0] = {c0, c0};
   end

   for (genvar s = 1; s <= LOG2W; s++) begin : g_dbl
      rdadd_dbl #(.WIDTH(WIDTH), .DIST(1 << (s-1))) u_dbl (
         .kpg_i (stg_q[s-1].kpg),
         .kpg_o (kpg_dbl[s])
      );
   end

   // Stage S: resolved KPG bit 0 of position i is the carry into i+1.
   always_comb begin
      c[0] = stg_q[LOG2W].c0;
      for (int i = 0; i < WIDTH; i++) c[i+1] = stg_q[LOG2W].kpg[i][0];
      s_sum = stg_q[LOG2W].p ^ c[WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe  <= '0;
         for (int s = 0; s <= LOG2W; s++) stg_q[s] <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else if (adv) begin
         vld_pipe[0] <= in_valid;
         stg_q[0]    <= g_d;
         for (int s = 1; s <= LOG2W; s++) begin
            vld_pipe[s]  <= vld_pipe[s-1];
            stg_q[s].kpg <= kpg_dbl[s];
            stg_q[s].p   <= stg_q[s-1].p;
            stg_q[s].c0  <= stg_q[s-1].c0;
         end
         out_valid <= vld_pipe[LOG2W];
         sum       <= s_sum;
         cout      <= c[WIDTH];
         ovf       <= c[WIDTH] ^ c[WIDTH-1];
         zero      <= ~|s_sum;
      end
   end
endmodule
